// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state/mode encodings and sizing helper for the N-way arbiter
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    RR    = 1'b0,
    FIXED = 1'b1
  } arb_mode_e;

  // Index width for n items; never below 1 so single-bit selects stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set request at or after start, or lowest index when fixed
module rr_pick
  import arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  input  logic            fixed,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW:0] k;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (fixed) begin
        k = (IW+1)'(i);
      end else begin
        k = {1'b0, start} + (IW+1)'(i);
        if (k >= (IW+1)'(NREQ)) k = k - (IW+1)'(NREQ);
      end
      if (req[k[IW-1:0]]) begin
        found = 1'b1;
        idx   = k[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/arbiter_rrn.sv
// rtl/arbiter_rrn.sv - N-requester bus arbiter with round-robin/fixed priority, owner-qualified finish and watchdog
module arbiter_rrn
  import arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 0,
  parameter int TMR_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        finish,
  input  logic                   prio_mode,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        sel,
  output logic [clog2(NREQ)-1:0] owner,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [clog2(NREQ)-1:0] err_id
);

  localparam int              IW       = clog2(NREQ);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
  localparam logic [TMR_W-1:0] WD_LAST = TMR_W'(TIMEOUT - 1);
  localparam bit              WD_EN    = (TIMEOUT != 0);

  arb_state_e       state, state_nxt;
  logic [IW-1:0]    last;
  logic [IW-1:0]    start;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [NREQ-1:0]  pick_hot;
  logic             fixed_mode;
  logic             fin_own;
  logic             wd_fire;
  logic             rel;
  logic             ae;
  logic [TMR_W-1:0] timer;

  // Only the current owner may end its tenure; everyone else's finish is noise.
  assign fin_own    = finish[owner];
  assign wd_fire    = WD_EN && (state == ARB_BUSY) && (timer == WD_LAST) && !fin_own;
  assign rel        = (state == ARB_BUSY) && (fin_own || wd_fire);
  assign ae         = (state == ARB_IDLE) || rel;
  assign start      = (last == LAST_IDX) ? '0 : last + 1'b1;
  assign fixed_mode = (arb_mode_e'(prio_mode) == FIXED);
  assign busy       = (state == ARB_BUSY);

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .start (start),
    .fixed (fixed_mode),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_hot           = '0;
    pick_hot[pick_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    if (ae) begin
      state_nxt = pick_found ? ARB_BUSY : ARB_IDLE;
      if (pick_found && rst_n) gnt = pick_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= '0;
      owner       <= '0;
      last        <= LAST_IDX;
      timer       <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      timeout_err <= wd_fire;
      if (wd_fire) err_id <= owner;
      if (ae) begin
        timer <= '0;
        if (pick_found) begin
          sel   <= pick_hot;
          owner <= pick_idx;
          last  <= pick_idx;
        end else begin
          sel <= '0;
        end
      end else if ((state == ARB_BUSY) && (timer != '1)) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rrn.sv
// tb/tb_arbiter_rrn.sv - vector table, corner sequences and randomized model check for arbiter_rrn
module tb_arbiter_rrn;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic [3:0] finish = 4'h0;
  logic       prio_mode = 1'b0;
  logic [3:0] gnt, sel;
  logic [1:0] owner, err_id;
  logic       busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  // reference state: held = busy cycles of the current tenure, counting the present one
  bit m_busy;
  int m_owner, m_last, m_held, m_errid;
  bit m_terr;

  typedef struct {
    logic [3:0] req;
    logic [3:0] fin;
    logic       mode;
    logic [3:0] gnt;
    logic [3:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[26];

  arbiter_rrn #(.NREQ(N), .TIMEOUT(TO), .TMR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .finish(finish), .prio_mode(prio_mode),
    .gnt(gnt), .sel(sel), .owner(owner), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] f, input logic m);
    @(negedge clk);
    req = r; finish = f; prio_mode = m;
    #1;
  endtask

  function automatic int pick(input logic [3:0] r, input logic m, input int lst);
    int k;
    for (int i = 0; i < N; i++) begin
      k = m ? i : (lst + 1 + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_held = 0; m_errid = 0; m_terr = 0;
  endtask

  task automatic model_cycle(input logic [3:0] r, input logic [3:0] f, input logic m);
    bit fo, wdf, ae;
    int w;
    logic [3:0] eg;
    drive(r, f, m);
    fo  = m_busy && f[m_owner];
    wdf = m_busy && (m_held == TO) && !fo;
    ae  = !m_busy || fo || wdf;
    w   = pick(r, m, m_last);
    eg  = (ae && w >= 0) ? 4'(1 << w) : 4'h0;
    chk("rnd_gnt", gnt, eg);
    chk("rnd_sel", sel, m_busy ? 4'(1 << m_owner) : 4'h0);
    chk("rnd_busy", busy, m_busy);
    if (m_busy) chk("rnd_owner", owner, m_owner);
    chk("rnd_terr", timeout_err, m_terr);
    chk("rnd_errid", err_id, m_errid);
    m_terr = wdf;
    if (wdf) m_errid = m_owner;
    if (ae) begin
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_last = w; m_held = 1;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy) begin
      m_held++;
    end
  endtask

  initial begin
    //          req    fin    mode  gnt    sel    busy
    tbl[0]  = '{4'hF, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1};
    tbl[2]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1};
    tbl[3]  = '{4'hF, 4'h1, 1'b0, 4'h2, 4'h1, 1'b1};
    tbl[4]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1};
    tbl[5]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1};
    tbl[6]  = '{4'hF, 4'h2, 1'b0, 4'h4, 4'h2, 1'b1};
    tbl[7]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h4, 1'b1};
    tbl[8]  = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h4, 1'b1};
    tbl[9]  = '{4'hF, 4'h4, 1'b0, 4'h8, 4'h4, 1'b1};
    tbl[10] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1};
    tbl[11] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h8, 1'b1};
    tbl[12] = '{4'hF, 4'h8, 1'b0, 4'h1, 4'h8, 1'b1};
    tbl[13] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h1, 1'b1};
    tbl[14] = '{4'hF, 4'h1, 1'b0, 4'h2, 4'h1, 1'b1};
    tbl[15] = '{4'hF, 4'h8, 1'b0, 4'h0, 4'h2, 1'b1};
    tbl[16] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 1'b1};
    tbl[17] = '{4'hF, 4'h2, 1'b0, 4'h4, 4'h2, 1'b1};
    tbl[18] = '{4'hB, 4'h0, 1'b1, 4'h0, 4'h4, 1'b1};
    tbl[19] = '{4'hB, 4'h4, 1'b1, 4'h1, 4'h4, 1'b1};
    tbl[20] = '{4'hA, 4'h0, 1'b1, 4'h0, 4'h1, 1'b1};
    tbl[21] = '{4'hA, 4'h1, 1'b1, 4'h2, 4'h1, 1'b1};
    tbl[22] = '{4'hA, 4'h0, 1'b1, 4'h0, 4'h2, 1'b1};
    tbl[23] = '{4'h1, 4'h2, 1'b0, 4'h1, 4'h2, 1'b1};
    tbl[24] = '{4'h0, 4'h1, 1'b0, 4'h0, 4'h1, 1'b1};
    tbl[25] = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0};

    // reset held with every master requesting
    req = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_sel", sel, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_terr", timeout_err, 1'b0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      req = tbl[i].req; finish = tbl[i].fin; prio_mode = tbl[i].mode;
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_terr", i), timeout_err, 1'b0);
    end

    // watchdog on master 2, then a finish exactly on the deadline cycle
    drive(4'h4, 4'h0, 1'b0);
    chk("wd_gnt0", gnt, 4'h4);
    for (int k = 1; k <= 17; k++) begin
      drive(4'h4, (k == 16) ? 4'h4 : 4'h0, 1'b0);
      chk($sformatf("wd%0d_gnt", k), gnt, (k == 8 || k == 16) ? 4'h4 : 4'h0);
      chk($sformatf("wd%0d_terr", k), timeout_err, (k == 9) ? 1'b1 : 1'b0);
      chk($sformatf("wd%0d_sel", k), sel, 4'h4);
      if (k >= 9) chk($sformatf("wd%0d_errid", k), err_id, 2'd2);
    end

    // asynchronous reset during ownership
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_sel", sel, 4'h0);
    chk("mrst_owner", owner, 2'd0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_gnt", gnt, 4'h0);
    chk("mrst_errid", err_id, 2'd0);
    req = 4'h0; finish = 4'h0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] r, f;
      r = 4'($urandom_range(15));
      if ($urandom_range(7) == 0) r = 4'h0;
      f = 4'h0;
      for (int b = 0; b < N; b++) if ($urandom_range(9) == 0) f[b] = 1'b1;
      if ((i / 200) % 2 == 1) model_cycle(r, f, 1'b1);
      else                    model_cycle(r, f, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
